alu_share_arbiter: RTL

//  Shares one combinational ALU (same 3-bit op encoding as the core ALU) between two requesters.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation in flight: IDLE (grant) -> EXEC (evaluate) -> RESP (hold result until taken).
module alu_share_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a_0,
  input  logic [WIDTH-1:0]     req_b_0,
  input  logic [2:0]           req_op_0,
  input  logic [WIDTH-1:0]     req_a_1,
  input  logic [WIDTH-1:0]     req_b_1,
  input  logic [2:0]           req_op_1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_lt,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] grant_cnt_0,
  output logic [CNT_WIDTH-1:0] grant_cnt_1
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_ptr, r_grant;
  logic [WIDTH-1:0]     r_a, r_b, r_result;
  logic [2:0]           r_op;
  logic                 r_zero, r_lt;
  logic [CNT_WIDTH-1:0] r_cnt_0, r_cnt_1;

  logic                 w_grant, w_req_hs, w_rsp_hs;
  logic [1:0]           w_req_ready;
  logic [WIDTH-1:0]     w_alu;
  logic                 w_zero, w_lt, w_ltu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant selection and handshakes; req_ready is held low while in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_grant     = 1'b0;
    w_req_hs    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid == 2'b11) w_grant = r_ptr;
        else                    w_grant = req_valid[1];
        if ((|req_valid) && rst_n) begin
          w_req_ready[w_grant] = 1'b1;
          w_req_hs             = 1'b1;
          w_state_nxt          = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready[r_grant]) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared ALU on the latched operands; flags always come from the operands.
  always_comb begin
    w_zero = (r_a == r_b);
    w_lt   = ($signed(r_a) < $signed(r_b));
    w_ltu  = (r_a < r_b);
    w_alu  = '0;
    case (r_op)
      3'b000: w_alu = r_a + r_b;
      3'b001: w_alu = r_a - r_b;
      3'b010: w_alu = r_a & r_b;
      3'b011: w_alu = r_a | r_b;
      3'b100: w_alu = r_b;
      3'b101: w_alu = WIDTH'(w_ltu);
      3'b110: w_alu = WIDTH'(w_lt);
      3'b111: w_alu = r_a ^ r_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_grant  <= 1'b0;
      r_ptr    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_a     <= w_grant ? req_a_1  : req_a_0;
        r_b     <= w_grant ? req_b_1  : req_b_0;
        r_op    <= w_grant ? req_op_1 : req_op_0;
        r_grant <= w_grant;
      end
      if (r_state == EXEC) begin
        r_result <= w_alu;
        r_zero   <= w_zero;
        r_lt     <= w_lt;
      end
      if (w_rsp_hs) r_ptr <= ~r_grant;
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_0 <= '0;
      r_cnt_1 <= '0;
    end else if (w_req_hs) begin
      if (!w_grant && (r_cnt_0 != CNT_MAX)) r_cnt_0 <= r_cnt_0 + CNT_WIDTH'(1);
      if (w_grant && (r_cnt_1 != CNT_MAX))  r_cnt_1 <= r_cnt_1 + CNT_WIDTH'(1);
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = (r_state == RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_lt      = r_lt;
  assign busy        = (r_state != IDLE);
  assign grant_cnt_0 = r_cnt_0;
  assign grant_cnt_1 = r_cnt_1;

endmodule
